// File: rtl/controlador_display_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display driver.
// Segment patterns are ordered gfedcba and are active-low (0 = segment lit).
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam int   N_DIGITOS  = 4;
  localparam seg_t SEG_BLANCO = 7'b1111111;

  localparam seg_t HEX_A_SEG [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

endpackage

// File: rtl/controlador_display_if.sv
// Load/configuration inputs and scan outputs of the display controller.
// The driver side uses master; the controller itself uses slave.
interface controlador_display_if;
  import display_pkg::*;

  logic        carga;
  logic [15:0] dato;
  logic        blanco_ceros;
  logic [1:0]  indice;
  seg_t        segmentos;
  logic        fin_barrido;

  modport master (
    output carga, dato, blanco_ceros,
    input  indice, segmentos, fin_barrido
  );

  modport slave (
    input  carga, dato, blanco_ceros,
    output indice, segmentos, fin_barrido
  );

endinterface

// File: rtl/decodificador_7seg.sv
// Combinational hex nibble to active-low 7-segment glyph, with forced blank.
module decodificador_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blanco,
  output seg_t       seg
);

  // Glyph lookup, overridden by the blank request
  always_comb begin
    seg = SEG_BLANCO;
    if (blanco) begin
      seg = SEG_BLANCO;
    end else begin
      seg = HEX_A_SEG[nibble];
    end
  end

endmodule

// File: rtl/controlador_display.sv
// Four-digit time-multiplexed 7-segment driver: prescaler, digit scan,
// tear-free value commit at scan wrap, and leading-zero blanking.
module controlador_display
  import display_pkg::*;
#(
  parameter int DIV_REFRESCO = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  controlador_display_if.slave  bus
);

  localparam int             PW      = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(DIV_REFRESCO - 1);

  logic [PW-1:0] pre_r;
  logic [1:0]    indice_r;
  logic [15:0]   visible_r;
  logic [15:0]   pendiente_r;
  logic          pend_r;
  logic          fin_barrido_r;

  logic          tick_s;
  logic          wrap_s;
  logic [3:0]    nibble_s;
  logic          blanco_s;
  seg_t          seg_s;

  assign tick_s = (pre_r == PRE_MAX);
  assign wrap_s = tick_s && (indice_r == 2'd3);

  // Refresh prescaler: one tick per digit slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_r <= '0;
    end else if (tick_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

  // Digit scan counter, 2-bit natural wrap 3 -> 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      indice_r <= 2'd0;
    end else if (tick_s) begin
      indice_r <= indice_r + 2'd1;
    end else begin
      indice_r <= indice_r;
    end
  end

  // Load/commit: values reach the display only on the wrap edge, so a frame
  // never mixes digits of two values. A load coinciding with wrap wins outright.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      visible_r   <= 16'h0000;
      pendiente_r <= 16'h0000;
      pend_r      <= 1'b0;
    end else if (bus.carga && wrap_s) begin
      visible_r   <= bus.dato;
      pend_r      <= 1'b0;
    end else if (bus.carga) begin
      pendiente_r <= bus.dato;
      pend_r      <= 1'b1;
    end else if (wrap_s) begin
      if (pend_r) begin
        visible_r <= pendiente_r;
      end else begin
        visible_r <= visible_r;
      end
      pend_r <= 1'b0;
    end else begin
      pend_r <= pend_r;
    end
  end

  // End-of-frame pulse, high the cycle after the wrap edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fin_barrido_r <= 1'b0;
    end else begin
      fin_barrido_r <= wrap_s;
    end
  end

  // Active nibble select and leading-zero blank qualifier (digit 0 always lit)
  always_comb begin
    nibble_s = 4'h0;
    blanco_s = 1'b0;
    case (indice_r)
      2'd0: begin
        nibble_s = visible_r[3:0];
        blanco_s = 1'b0;
      end
      2'd1: begin
        nibble_s = visible_r[7:4];
        blanco_s = bus.blanco_ceros && (visible_r[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_s = visible_r[11:8];
        blanco_s = bus.blanco_ceros && (visible_r[15:8] == 8'h00);
      end
      2'd3: begin
        nibble_s = visible_r[15:12];
        blanco_s = bus.blanco_ceros && (visible_r[15:12] == 4'h0);
      end
      default: begin
        nibble_s = 4'h0;
        blanco_s = 1'b0;
      end
    endcase
  end

  decodificador_7seg u_dec (
    .nibble (nibble_s),
    .blanco (blanco_s),
    .seg    (seg_s)
  );

  assign bus.indice      = indice_r;
  assign bus.segmentos   = seg_s;
  assign bus.fin_barrido = fin_barrido_r;

endmodule
